wasm_instr_loader: RTL and testbench

Byte-stream loader that fills the instruction BRAM of the WASM core before execution. It sits directly upstream of the instruction memory controller's write port. It accepts WebAssembly bytecode one byte per cycle over a valid/ready handshake and packs the bytes into write-window words. It drives the controller's `we` / `write_pointer_shift_minusone` / `wr_data` port, and holds the core in reset until the image is complete.

---
 rtl/wasm_instr_loader_pkg.sv | 38 +++
 rtl/wasm_byte_packer.sv | 70 +++++++
 rtl/wasm_instr_loader.sv | 163 ++++++++++++++++
 tb/tb_wasm_instr_loader.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wasm_instr_loader_pkg.sv
// ============================================================================
// Module      : wasm_instr_loader_pkg
// Description : Shared types and constants for the WASM instruction loader:
//               FSM state encoding, bytecode magic word and write-window
//               widths tied to the instruction memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wasm_instr_loader_pkg;

  // Instruction memory controller geometry the loader must match
  localparam int c_INSTR_WRITE_WIDTH     = 32;
  localparam int c_LOG_WRITE_WINDOW_SIZE = 2;
  localparam int c_INSTR_BRAM_DEPTH      = 256;

  localparam int c_WR_BYTES  = c_INSTR_WRITE_WIDTH / 8;
  localparam int c_CNT_WIDTH = $clog2(c_INSTR_BRAM_DEPTH) + 1;

  // WebAssembly module header "\0asm", first byte in the low lane
  localparam logic [31:0] c_MAGIC_WORD  = 32'h6D736100;
  localparam int          c_MAGIC_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } loader_state_t;

  // Expected header byte at position idx
  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    return c_MAGIC_WORD[{idx, 3'b000} +: 8];
  endfunction

endpackage

`default_nettype wire

// File: rtl/wasm_byte_packer.sv
// ============================================================================
// Module      : wasm_byte_packer
// Description : Packs accepted bytes into write-window words. Flushes a word
//               when the window fills or a flush is requested, producing a
//               one-cycle write strobe with the word and its byte count - 1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wasm_byte_packer #(
  parameter int WR_BYTES     = 4,
  parameter int LOG_WR_BYTES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_clear,
  input  logic                    i_byte_valid,
  input  logic [7:0]              i_byte_data,
  input  logic                    i_flush_req,
  output logic                    o_flush,
  output logic [LOG_WR_BYTES:0]   o_flush_nbytes,
  output logic                    o_we,
  output logic [LOG_WR_BYTES-1:0] o_write_pointer_shift_minusone,
  output logic [8*WR_BYTES-1:0]   o_wr_data
);

  logic [8*WR_BYTES-1:0]   r_pack;
  logic [8*WR_BYTES-1:0]   w_pack_next;
  logic [LOG_WR_BYTES-1:0] r_pack_cnt;

  // Current pack register with the incoming byte dropped into its slot
  always_comb begin
    w_pack_next = r_pack;
    w_pack_next[{r_pack_cnt, 3'b000} +: 8] = i_byte_data;
  end

  // The slot counter never holds WR_BYTES: the byte filling the last slot flushes
  assign o_flush        = i_byte_valid &
                          ((r_pack_cnt == LOG_WR_BYTES'(WR_BYTES - 1)) | i_flush_req);
  assign o_flush_nbytes = {1'b0, r_pack_cnt} + 1'b1;

  // Pack register, slot counter and registered write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pack                         <= '0;
      r_pack_cnt                     <= '0;
      o_we                           <= 1'b0;
      o_wr_data                      <= '0;
      o_write_pointer_shift_minusone <= '0;
    end else begin
      o_we <= o_flush;
      if (i_clear) begin
        r_pack     <= '0;
        r_pack_cnt <= '0;
      end else if (o_flush) begin
        // r_pack is kept zero above the fill point, so unused lanes go out as 0
        o_wr_data                      <= w_pack_next;
        o_write_pointer_shift_minusone <= r_pack_cnt;
        r_pack                         <= '0;
        r_pack_cnt                     <= '0;
      end else if (i_byte_valid) begin
        r_pack     <= w_pack_next;
        r_pack_cnt <= r_pack_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/wasm_instr_loader.sv
// ============================================================================
// Module      : wasm_instr_loader
// Description : Streams WebAssembly bytecode into the instruction BRAM write
//               port, one byte per cycle, packed into write-window words.
//               Holds the core in reset until the whole image is written and
//               flags images larger than the BRAM.
//               Optional header check: define WASM_LOADER_MAGIC_CHECK_EN to
//               require and strip the 00 61 73 6D module header.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wasm_instr_loader
  import wasm_instr_loader_pkg::*;
#(
  parameter int WR_BYTES     = c_WR_BYTES,
  parameter int LOG_WR_BYTES = c_LOG_WRITE_WINDOW_SIZE,
  parameter int DEPTH        = c_INSTR_BRAM_DEPTH,
  parameter int CNT_WIDTH    = c_CNT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic [7:0]              s_data,
  input  logic                    s_valid,
  input  logic                    s_last,
  output logic                    s_ready,
  output logic                    o_we,
  output logic [LOG_WR_BYTES-1:0] o_write_pointer_shift_minusone,
  output logic [8*WR_BYTES-1:0]   o_wr_data,
  output logic [CNT_WIDTH-1:0]    o_byte_cnt,
  output logic                    o_done,
  output logic                    o_overflow,
  output logic                    o_magic_error,
  output logic                    o_core_rst_n
);

  loader_state_t         r_state;
  logic                  r_done;
  logic                  r_overflow;
  logic                  r_core_rst_n;
  logic [CNT_WIDTH-1:0]  r_byte_cnt;
  logic [CNT_WIDTH-1:0]  r_accept_cnt;

  logic                  w_accept;
  logic                  w_start;
  logic                  w_byte_write;
  logic                  w_hit_depth;
  logic                  w_flush_req;
  logic                  w_flush;
  logic [LOG_WR_BYTES:0] w_flush_nbytes;
  logic [CNT_WIDTH-1:0]  w_total_next;

  assign s_ready  = (r_state == ST_LOAD);
  assign w_accept = s_valid & s_ready;
  // A start pulse during LOAD is ignored
  assign w_start  = i_start & (r_state != ST_LOAD);

`ifdef WASM_LOADER_MAGIC_CHECK_EN
  logic [2:0] r_hdr_cnt;
  logic       r_magic_error;
  logic       w_in_hdr;
  logic       w_hdr_bad;

  // Header bytes are consumed here and never reach the packer
  assign w_in_hdr      = (r_hdr_cnt < 3'(c_MAGIC_BYTES));
  assign w_hdr_bad     = w_accept & w_in_hdr &
                         ((s_data != magic_byte(r_hdr_cnt[1:0])) | s_last);
  assign w_byte_write  = w_accept & ~w_in_hdr;
  assign o_magic_error = r_magic_error;
`else
  assign w_byte_write  = w_accept;
  assign o_magic_error = 1'b0;
`endif

  // The byte that fills the BRAM forces a flush even without s_last
  assign w_total_next = r_accept_cnt + 1'b1;
  assign w_hit_depth  = w_byte_write & (w_total_next == CNT_WIDTH'(DEPTH));
  assign w_flush_req  = s_last | w_hit_depth;

  wasm_byte_packer #(
    .WR_BYTES     (WR_BYTES),
    .LOG_WR_BYTES (LOG_WR_BYTES)
  ) u_packer (
    .clk                            (clk),
    .rst_n                          (rst_n),
    .i_clear                        (w_start),
    .i_byte_valid                   (w_byte_write),
    .i_byte_data                    (s_data),
    .i_flush_req                    (w_flush_req),
    .o_flush                        (w_flush),
    .o_flush_nbytes                 (w_flush_nbytes),
    .o_we                           (o_we),
    .o_write_pointer_shift_minusone (o_write_pointer_shift_minusone),
    .o_wr_data                      (o_wr_data)
  );

  // Load FSM with byte counters, status flags and core reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_done        <= 1'b0;
      r_overflow    <= 1'b0;
      r_core_rst_n  <= 1'b0;
      r_byte_cnt    <= '0;
      r_accept_cnt  <= '0;
`ifdef WASM_LOADER_MAGIC_CHECK_EN
      r_hdr_cnt     <= '0;
      r_magic_error <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_LOAD: begin
          // Byte count moves with the strobe so it matches what was written
          if (w_flush)
            r_byte_cnt <= r_byte_cnt + CNT_WIDTH'(w_flush_nbytes);
          if (w_byte_write)
            r_accept_cnt <= w_total_next;
          if (w_byte_write && s_last) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else if (w_hit_depth) begin
            r_state    <= ST_ERROR;
            r_overflow <= 1'b1;
          end
`ifdef WASM_LOADER_MAGIC_CHECK_EN
          if (w_accept && w_in_hdr) begin
            if (w_hdr_bad) begin
              r_state       <= ST_ERROR;
              r_magic_error <= 1'b1;
            end else begin
              r_hdr_cnt <= r_hdr_cnt + 3'd1;
            end
          end
`endif
        end
        default: begin
          if (i_start) begin
            r_state       <= ST_LOAD;
            r_done        <= 1'b0;
            r_overflow    <= 1'b0;
            r_byte_cnt    <= '0;
            r_accept_cnt  <= '0;
`ifdef WASM_LOADER_MAGIC_CHECK_EN
            r_hdr_cnt     <= '0;
            r_magic_error <= 1'b0;
`endif
          end
        end
      endcase
      // Released one cycle after entering DONE, dropped one cycle after leaving
      r_core_rst_n <= (r_state == ST_DONE);
    end
  end

  assign o_done       = r_done;
  assign o_overflow   = r_overflow;
  assign o_core_rst_n = r_core_rst_n;
  assign o_byte_cnt   = r_byte_cnt;

endmodule

`default_nettype wire

// File: tb/tb_wasm_instr_loader.sv
// ============================================================================
// Module      : tb_wasm_instr_loader
// Description : Directed self-checking bench for wasm_instr_loader. One
//               instance at default depth, one with DEPTH = 8 for overflow.
//               Expected write strobes are queued as stimulus is driven and
//               popped when the DUT strobes. Header tests follow
//               WASM_LOADER_MAGIC_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wasm_instr_loader;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  // Instance A: default geometry
  logic       a_start, a_valid, a_last, a_ready;
  logic [7:0] a_data;
  logic       a_we, a_done, a_ovf, a_mag, a_crst;
  logic [1:0] a_shift;
  logic [31:0] a_wdata;
  logic [8:0] a_cnt;

  // Instance B: 8-byte BRAM
  logic       b_start, b_valid, b_last, b_ready;
  logic [7:0] b_data;
  logic       b_we, b_done, b_ovf, b_mag, b_crst;
  logic [1:0] b_shift;
  logic [31:0] b_wdata;
  logic [3:0] b_cnt;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  shift;
    logic        done;
  } wr_t;

  wr_t qa[$];
  wr_t qb[$];

  int n_cmp = 0;
  int n_err = 0;

  wasm_instr_loader u_dut_a (
    .clk                            (clk),
    .rst_n                          (rst_n),
    .i_start                        (a_start),
    .s_data                         (a_data),
    .s_valid                        (a_valid),
    .s_last                         (a_last),
    .s_ready                        (a_ready),
    .o_we                           (a_we),
    .o_write_pointer_shift_minusone (a_shift),
    .o_wr_data                      (a_wdata),
    .o_byte_cnt                     (a_cnt),
    .o_done                         (a_done),
    .o_overflow                     (a_ovf),
    .o_magic_error                  (a_mag),
    .o_core_rst_n                   (a_crst)
  );

  wasm_instr_loader #(
    .WR_BYTES     (4),
    .LOG_WR_BYTES (2),
    .DEPTH        (8),
    .CNT_WIDTH    (4)
  ) u_dut_b (
    .clk                            (clk),
    .rst_n                          (rst_n),
    .i_start                        (b_start),
    .s_data                         (b_data),
    .s_valid                        (b_valid),
    .s_last                         (b_last),
    .s_ready                        (b_ready),
    .o_we                           (b_we),
    .o_write_pointer_shift_minusone (b_shift),
    .o_wr_data                      (b_wdata),
    .o_byte_cnt                     (b_cnt),
    .o_done                         (b_done),
    .o_overflow                     (b_ovf),
    .o_magic_error                  (b_mag),
    .o_core_rst_n                   (b_crst)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input logic [31:0] d, input logic [1:0] s, input logic dn);
    wr_t e;
    e.data = d; e.shift = s; e.done = dn;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [31:0] d, input logic [1:0] s, input logic dn);
    wr_t e;
    e.data = d; e.shift = s; e.done = dn;
    qb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte and return just after the edge that accepted it
  task automatic send_a(input logic [7:0] d, input logic l);
    int t;
    t = 0;
    a_data = d; a_valid = 1'b1; a_last = l;
    while (a_ready !== 1'b1 && t < 20) begin
      step();
      t++;
    end
    if (t >= 20) chk("a_send_timeout", a_ready, 1);
    step();
  endtask

  task automatic send_b(input logic [7:0] d, input logic l);
    int t;
    t = 0;
    b_data = d; b_valid = 1'b1; b_last = l;
    while (b_ready !== 1'b1 && t < 20) begin
      step();
      t++;
    end
    if (t >= 20) chk("b_send_timeout", b_ready, 1);
    step();
  endtask

  task automatic start_a();
    a_start = 1'b1;
    step();
    a_start = 1'b0;
  endtask

  task automatic start_b();
    b_start = 1'b1;
    step();
    b_start = 1'b0;
  endtask

  // Scoreboard: every strobe must match the oldest queued expectation
  always @(negedge clk) begin
    wr_t e;
    if (a_we === 1'b1) begin
      if (qa.size() == 0) chk("a_unexpected_we", a_we, 0);
      else begin
        e = qa.pop_front();
        chk("a_wr_data", a_wdata, e.data);
        chk("a_shift_minusone", a_shift, e.shift);
        chk("a_done_with_we", a_done, e.done);
      end
    end
    if (b_we === 1'b1) begin
      if (qb.size() == 0) chk("b_unexpected_we", b_we, 0);
      else begin
        e = qb.pop_front();
        chk("b_wr_data", b_wdata, e.data);
        chk("b_shift_minusone", b_shift, e.shift);
        chk("b_done_with_we", b_done, e.done);
      end
    end
  end

  initial begin
    a_start = 0; a_valid = 0; a_last = 0; a_data = 0;
    b_start = 0; b_valid = 0; b_last = 0; b_data = 0;
    rst_n = 1'b0;
    repeat (3) step();

    // Reset values
    chk("rst_a_ready", a_ready, 0);
    chk("rst_a_we", a_we, 0);
    chk("rst_a_done", a_done, 0);
    chk("rst_a_ovf", a_ovf, 0);
    chk("rst_a_magic", a_mag, 0);
    chk("rst_a_core_rst_n", a_crst, 0);
    chk("rst_a_wr_data", a_wdata, 0);
    chk("rst_a_shift", a_shift, 0);
    chk("rst_a_byte_cnt", a_cnt, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_b_ovf", b_ovf, 0);
    rst_n = 1'b1;
    step();

    // Eight bytes, two full words
    start_a();
    chk("t1_ready_after_start", a_ready, 1);
`ifdef WASM_LOADER_MAGIC_CHECK_EN
    send_a(8'h00, 0); send_a(8'h61, 0); send_a(8'h73, 0); send_a(8'h6D, 0);
`endif
    push_a(32'h04030201, 2'd3, 1'b0);
    push_a(32'h08070605, 2'd3, 1'b1);
    for (int i = 1; i <= 8; i++) send_a(8'(i), i == 8);
    a_valid = 0; a_last = 0;
    chk("t1_done", a_done, 1);
    chk("t1_core_rst_n_lags", a_crst, 0);
    chk("t1_byte_cnt", a_cnt, 8);
    step();
    chk("t1_core_rst_n", a_crst, 1);
    chk("t1_ready_done", a_ready, 0);
    chk("t1_queue_empty", qa.size(), 0);

    // Six bytes, partial last word
    start_a();
    chk("t2_done_cleared", a_done, 0);
    chk("t2_cnt_cleared", a_cnt, 0);
`ifdef WASM_LOADER_MAGIC_CHECK_EN
    send_a(8'h00, 0); send_a(8'h61, 0); send_a(8'h73, 0); send_a(8'h6D, 0);
`endif
    push_a(32'h04030201, 2'd3, 1'b0);
    push_a(32'h00000605, 2'd1, 1'b1);
    for (int i = 1; i <= 6; i++) send_a(8'(i), i == 6);
    a_valid = 0; a_last = 0;
    chk("t2_done", a_done, 1);
    chk("t2_byte_cnt", a_cnt, 6);
    chk("t2_core_rst_n_lags", a_crst, 0);
    step();
    chk("t2_core_rst_n", a_crst, 1);
    chk("t2_queue_empty", qa.size(), 0);

    // Header bytes followed by a two-byte body
    start_a();
`ifdef WASM_LOADER_MAGIC_CHECK_EN
    push_a(32'h0000BBAA, 2'd1, 1'b1);
`else
    push_a(32'h6D736100, 2'd3, 1'b0);
    push_a(32'h0000BBAA, 2'd1, 1'b1);
`endif
    send_a(8'h00, 0); send_a(8'h61, 0); send_a(8'h73, 0); send_a(8'h6D, 0);
    send_a(8'hAA, 0); send_a(8'hBB, 1);
    a_valid = 0; a_last = 0;
    step();
`ifdef WASM_LOADER_MAGIC_CHECK_EN
    chk("t3_byte_cnt", a_cnt, 2);
`else
    chk("t3_byte_cnt", a_cnt, 6);
`endif
    chk("t3_magic", a_mag, 0);
    chk("t3_done", a_done, 1);
    chk("t3_queue_empty", qa.size(), 0);

`ifdef WASM_LOADER_MAGIC_CHECK_EN
    // Corrupt header: error after the third byte, nothing written
    start_a();
    send_a(8'h00, 0); send_a(8'h61, 0); send_a(8'h74, 0);
    a_valid = 0;
    chk("t4_magic_error", a_mag, 1);
    chk("t4_ready", a_ready, 0);
    chk("t4_ovf", a_ovf, 0);
    repeat (2) step();
    chk("t4_core_rst_n", a_crst, 0);
    start_a();
    chk("t4_magic_cleared", a_mag, 0);
    chk("t4_ready_reload", a_ready, 1);
`endif

    // Reset in the middle of a 12-byte load
    start_a();
`ifdef WASM_LOADER_MAGIC_CHECK_EN
    send_a(8'h00, 0); send_a(8'h61, 0); send_a(8'h73, 0); send_a(8'h6D, 0);
`endif
    push_a(32'h04030201, 2'd3, 1'b0);
    for (int i = 1; i <= 5; i++) send_a(8'(i), 0);
    a_data = 8'h06;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_ready", a_ready, 0);
    chk("t5_async_we", a_we, 0);
    chk("t5_async_wr_data", a_wdata, 0);
    chk("t5_async_shift", a_shift, 0);
    chk("t5_async_byte_cnt", a_cnt, 0);
    chk("t5_async_done", a_done, 0);
    chk("t5_async_core_rst_n", a_crst, 0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("t5_idle_ready", a_ready, 0);
    chk("t5_byte_cnt", a_cnt, 0);
    chk("t5_queue_empty", qa.size(), 0);
    a_valid = 0;

    // Overflow on the 8-byte instance
    start_b();
`ifdef WASM_LOADER_MAGIC_CHECK_EN
    send_b(8'h00, 0); send_b(8'h61, 0); send_b(8'h73, 0); send_b(8'h6D, 0);
`endif
    push_b(32'h04030201, 2'd3, 1'b0);
    push_b(32'h08070605, 2'd3, 1'b0);
    for (int i = 1; i <= 8; i++) send_b(8'(i), 0);
    b_data = 8'h09;
    chk("t6_overflow", b_ovf, 1);
    chk("t6_ready_9th", b_ready, 0);
    chk("t6_done", b_done, 0);
    repeat (3) step();
    chk("t6_ready_held", b_ready, 0);
    chk("t6_byte_cnt", b_cnt, 8);
    chk("t6_core_rst_n", b_crst, 0);
    chk("t6_overflow_sticky", b_ovf, 1);
    chk("t6_queue_empty", qb.size(), 0);
    b_valid = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
